// File: rtl/stage_control_pipe_pkg.sv
// -----------------------------------------------------------------------------
// stage_ctrl_pkg
//   Shared types for the stage_control_pipe handshake pipeline.
//   - l_state_e : left (capture) side state of a stage cell
//   - r_state_e : right (hand-off) side state of a stage cell
//   - cnt_width : width needed to hold an occupancy count of 0..depth
// -----------------------------------------------------------------------------
package stage_ctrl_pkg;

  typedef enum logic {
    L_IDLE = 1'b0,
    L_ACK  = 1'b1
  } l_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RET  = 2'd2
  } r_state_e;

  // Occupancy ranges over 0..depth inclusive, hence depth+1 codes.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stage_control_pipe_if.sv
// -----------------------------------------------------------------------------
// stage_control_pipe_if
//   Bundles the upstream/downstream 4-phase handshakes and the per-stage
//   visibility signals of stage_control_pipe.
//   master : the environment (producer + consumer) side
//   slave  : the pipeline side
//   Signals: req_in/data_in/ack_out (upstream), req_out/data_out/ack_in
//   (downstream), c (capture strobes), p (occupied flags), count (occupancy).
// -----------------------------------------------------------------------------
interface stage_control_pipe_if
  import stage_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = cnt_width(DEPTH)
);

  logic             req_in;
  logic [WIDTH-1:0] data_in;
  logic             ack_out;
  logic             req_out;
  logic [WIDTH-1:0] data_out;
  logic             ack_in;
  logic [DEPTH-1:0] c;
  logic [DEPTH-1:0] p;
  logic [CNT_W-1:0] count;

  modport master (
    output req_in, data_in, ack_in,
    input  ack_out, req_out, data_out, c, p, count
  );

  modport slave (
    input  req_in, data_in, ack_in,
    output ack_out, req_out, data_out, c, p, count
  );

endinterface

// File: rtl/stage_control_pipe_cell.sv
// -----------------------------------------------------------------------------
// stage_ctrl_cell
//   One clocked 4-phase bundled-data stage with a WIDTH-bit data register.
//   The left (capture) and right (hand-off) handshakes run as two independent
//   FSMs coupled only through the full flag, so a stage can start refilling
//   as soon as its token has been acknowledged downstream, even while the
//   downstream return-to-zero phase is still in progress.
//
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset
//     lreq, ldata    request + data from the upstream neighbour
//     lack           acknowledge to the upstream neighbour
//     rreq, rdata    request + data to the downstream neighbour
//     rack           acknowledge from the downstream neighbour
//     full           stage holds a token
//     full_nxt       value full takes at the next edge (for the count reg)
//     cap            one-cycle pulse in the cycle after a capture
// -----------------------------------------------------------------------------
module stage_ctrl_cell
  import stage_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lreq,
  input  logic [WIDTH-1:0] ldata,
  output logic             lack,
  output logic             rreq,
  output logic [WIDTH-1:0] rdata,
  input  logic             rack,
  output logic             full,
  output logic             full_nxt,
  output logic             cap
);

  l_state_e         l_state_q, l_state_d;
  r_state_e         r_state_q, r_state_d;
  logic             lack_q, lack_d;
  logic             rreq_q, rreq_d;
  logic             full_q, full_d;
  logic             cap_q, cap_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             set_full, clr_full;

  // Left side: capture only on the registered full flag (no bypass), so a
  // slot freed at edge n is reusable at edge n+1 at the earliest.
  always_comb begin
    l_state_d = l_state_q;
    lack_d    = lack_q;
    data_d    = data_q;
    cap_d     = 1'b0;
    set_full  = 1'b0;
    unique case (l_state_q)
      L_IDLE: begin
        if (lreq && !full_q) begin
          set_full  = 1'b1;
          cap_d     = 1'b1;
          data_d    = ldata;
          lack_d    = 1'b1;
          l_state_d = L_ACK;
        end
      end
      L_ACK: begin
        // Holding here until lreq drops keeps a long request from being
        // captured twice.
        if (!lreq) begin
          lack_d    = 1'b0;
          l_state_d = L_IDLE;
        end
      end
    endcase
  end

  // Right side: offer the token, free the slot on ack, then wait for the
  // downstream return-to-zero before offering the next one.
  always_comb begin
    r_state_d = r_state_q;
    rreq_d    = rreq_q;
    clr_full  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (full_q) begin
          rreq_d    = 1'b1;
          r_state_d = R_REQ;
        end
      end
      R_REQ: begin
        if (rack) begin
          rreq_d    = 1'b0;
          clr_full  = 1'b1;
          r_state_d = R_RET;
        end
      end
      R_RET: begin
        if (!rack) r_state_d = R_IDLE;
      end
      default: begin
        rreq_d    = 1'b0;
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Set needs full_q=0 and clear needs full_q=1 (R_REQ only follows a full
  // slot), so they never coincide; clear is still given priority.
  always_comb begin
    full_d = full_q;
    if (clr_full)      full_d = 1'b0;
    else if (set_full) full_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l_state_q <= L_IDLE;
      r_state_q <= R_IDLE;
      lack_q    <= 1'b0;
      rreq_q    <= 1'b0;
      full_q    <= 1'b0;
      cap_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      l_state_q <= l_state_d;
      r_state_q <= r_state_d;
      lack_q    <= lack_d;
      rreq_q    <= rreq_d;
      full_q    <= full_d;
      cap_q     <= cap_d;
      data_q    <= data_d;
    end
  end

  a_no_set_clr: assert property (@(posedge clk) disable iff (!rst_n) !(set_full && clr_full));

  assign lack     = lack_q;
  assign rreq     = rreq_q;
  assign rdata    = data_q;
  assign full     = full_q;
  assign full_nxt = full_d;
  assign cap      = cap_q;

endmodule

// File: rtl/stage_control_pipe.sv
// -----------------------------------------------------------------------------
// stage_control_pipe
//   DEPTH-stage clocked 4-phase handshake pipeline with WIDTH-bit data.
//   Strict FIFO: tokens enter on req_in/ack_out and leave on req_out/ack_in.
//   A token offered to an empty pipe appears at req_out 2*DEPTH edges later.
//
//   Ports:
//     clk    single clock, all state on the rising edge
//     rst_n  synchronous active-low reset, clears tokens and handshakes
//     bus    stage_control_pipe_if.slave:
//              req_in, data_in, ack_out   upstream 4-phase port
//              req_out, data_out, ack_in  downstream 4-phase port
//              c      per-stage capture pulse
//              p      per-stage occupied flag
//              count  number of occupied stages (registered, tracks p)
// -----------------------------------------------------------------------------
module stage_control_pipe
  import stage_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stage_control_pipe_if.slave   bus
);

  // Index k of each chain is the left side of cell k; index k+1 its right.
  logic [DEPTH:0]            req_chain;
  logic [DEPTH:0]            ack_chain;
  logic [DEPTH:0][WIDTH-1:0] data_chain;
  logic [DEPTH-1:0]          full;
  logic [DEPTH-1:0]          full_nxt;
  logic [DEPTH-1:0]          cap;
  logic [CNT_W-1:0]          count_q, count_d;

  assign req_chain[0]     = bus.req_in;
  assign data_chain[0]    = bus.data_in;
  assign ack_chain[DEPTH] = bus.ack_in;

  for (genvar k = 0; k < DEPTH; k++) begin : g_cell
    stage_ctrl_cell #(.WIDTH(WIDTH)) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .lreq     (req_chain[k]),
      .ldata    (data_chain[k]),
      .lack     (ack_chain[k]),
      .rreq     (req_chain[k+1]),
      .rdata    (data_chain[k+1]),
      .rack     (ack_chain[k+1]),
      .full     (full[k]),
      .full_nxt (full_nxt[k]),
      .cap      (cap[k])
    );
  end

  // Count is the popcount of next-state full flags, so the registered count
  // lines up with p in the same cycle instead of trailing it by one.
  always_comb begin
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CNT_W'(full_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  a_count_tracks_p: assert property (@(posedge clk) disable iff (!rst_n)
                                     32'(count_q) == $countones(full));

  assign bus.ack_out  = ack_chain[0];
  assign bus.req_out  = req_chain[DEPTH];
  assign bus.data_out = data_chain[DEPTH];
  assign bus.c        = cap;
  assign bus.p        = full;
  assign bus.count    = count_q;

endmodule
